usb_endpoint_in: RTL and testbench

//  Device-to-host (IN) endpoint: buffers application bytes in a transactional FIFO and splits them into packets of at most MAX_PACKET_SIZE.

---
 rtl/usb_ep_pkg.sv | 5 +
 rtl/usb_packet_pkg.sv | 7 +
 rtl/usb_endpoint_in_if.sv | 23 ++
 rtl/usb_ep_in_fifo.sv | 56 +++++
 rtl/usb_endpoint_in.sv | 154 +++++++++++++++
 tb/tb_usb_endpoint_in.sv | 264 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/usb_ep_pkg.sv
// Endpoint-level types: endpoint transfer type and the IN packetizer states.
package usb_ep_pkg;
  typedef enum logic [2:0] {NONE, CONTROL, BULK, INTERRUPT, ISOCHRONOUS} EpType;
  typedef enum logic [1:0] {IN_IDLE, IN_SEND, IN_WAIT_HS} InState;
endpackage

// File: rtl/usb_packet_pkg.sv
// PID[3:2] encodings used to select the IN response packet.
package usb_packet_pkg;
  localparam logic [1:0] RES_STALL = 2'b11;
  localparam logic [1:0] RES_NAK   = 2'b10;
  localparam logic [1:0] DATA0     = 2'b00;
  localparam logic [1:0] DATA1     = 2'b10;
endpackage

// File: rtl/usb_endpoint_in_if.sv
// Application fill port and transmitter byte stream of the IN endpoint.
interface usb_endpoint_in_if;
  logic       EP_IN_fillTransDone_i;
  logic       EP_IN_fillTransSuccess_i;
  logic       EP_IN_dataValid_i;
  logic [7:0] EP_IN_data_i;
  logic       EP_IN_full_o;
  logic       txPopData_i;
  logic       txDataAvailable_o;
  logic       txIsLastPacketByte_o;
  logic [7:0] txData_o;

  modport slave (
    input  EP_IN_fillTransDone_i, EP_IN_fillTransSuccess_i, EP_IN_dataValid_i, EP_IN_data_i,
    input  txPopData_i,
    output EP_IN_full_o, txDataAvailable_o, txIsLastPacketByte_o, txData_o
  );
  modport master (
    output EP_IN_fillTransDone_i, EP_IN_fillTransSuccess_i, EP_IN_dataValid_i, EP_IN_data_i,
    output txPopData_i,
    input  EP_IN_full_o, txDataAvailable_o, txIsLastPacketByte_o, txData_o
  );
endinterface

// File: rtl/usb_ep_in_fifo.sv
// Byte FIFO with transactional write (commit/discard) and read (commit/rollback).
// Occupancy is measured against the read commit pointer so unacked bytes stay stored.
module usb_ep_in_fifo #(
  parameter int ADDR_WID = 9
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [7:0]          wr_data_i,
  input  logic                fill_done_i,
  input  logic                fill_ok_i,
  input  logic                rd_adv_i,
  input  logic                rd_commit_i,
  input  logic                rd_rollback_i,
  output logic                full_o,
  output logic [7:0]          rd_data_o,
  output logic [ADDR_WID-1:0] rd_o,
  output logic [ADDR_WID-1:0] wr_commit_o,
  output logic [ADDR_WID-1:0] rd_commit_o
);
  logic [7:0]          r_mem [2**ADDR_WID];
  logic [7:0]          r_rdData;
  logic [ADDR_WID-1:0] r_wr, r_wrCommit, r_rd, r_rdCommit;
  logic [ADDR_WID-1:0] w_rdNext;
  logic                w_wrAcc;

  assign full_o      = ADDR_WID'(r_wr + 1'b1) == r_rdCommit;
  assign w_wrAcc     = wr_en_i && !full_o;
  assign w_rdNext    = ADDR_WID'(r_rd + 1'b1);
  assign rd_data_o   = r_rdData;
  assign rd_o        = r_rd;
  assign wr_commit_o = r_wrCommit;
  assign rd_commit_o = r_rdCommit;

  always_ff @(posedge clk_i) begin
    if (w_wrAcc) r_mem[r_wr] <= wr_data_i;
    r_rdData <= r_mem[r_rd];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr       <= '0;
      r_wrCommit <= '0;
      r_rd       <= '0;
      r_rdCommit <= '0;
    end else begin
      if (fill_done_i && !fill_ok_i) r_wr <= r_wrCommit;
      else if (w_wrAcc)              r_wr <= ADDR_WID'(r_wr + 1'b1);
      if (fill_done_i && fill_ok_i)  r_wrCommit <= r_wr;
      if (rd_rollback_i)             r_rd <= r_rdCommit;
      else if (rd_adv_i)             r_rd <= w_rdNext;
      // Isochronous commits on the same cycle as the final pop.
      if (rd_commit_i)               r_rdCommit <= rd_adv_i ? w_rdNext : r_rd;
    end
  end
endmodule

// File: rtl/usb_endpoint_in.sv
// USB IN endpoint: packetizes committed FIFO bytes, selects DATAx/NAK/STALL, commits on ACK.
// Optional macro USB_EP_IN_ZLP_EN adds a zero-length packet after an exact-MPS final packet.
module usb_endpoint_in
  import usb_ep_pkg::*;
  import usb_packet_pkg::*;
#(
  parameter EpType EP_TYPE         = BULK,
  parameter int    MAX_PACKET_SIZE = 64,
  parameter int    FIFO_ADDR_WID   = 9
) (
  input  logic             clk12_i,
  input  logic             rst12_i,
  input  logic             gotTransStartPacket_i,
  input  logic [1:0]       transStartTokenID_i,
  input  logic             resetDataToggle_i,
  usb_endpoint_in_if.slave ep_if,
  input  logic             gotAck_i,
  input  logic             hsTimeout_i,
  output logic             respValid_o,
  output logic             respHandshakePID_o,
  output logic [1:0]       respPacketID_o
);
  localparam bit STALL_EP = (EP_TYPE == NONE) || (EP_TYPE == CONTROL);
  localparam bit ISO_EP   = (EP_TYPE == ISOCHRONOUS);
  localparam int CNT_W    = $clog2(MAX_PACKET_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PACKET_SIZE - 1);

  logic [FIFO_ADDR_WID-1:0] w_rd, w_wrCommit, w_rdCommit;
  logic [7:0]               w_rdData;
  logic                     w_full, w_inTok, w_hasData, w_zlpReq, w_pop, w_last;
  logic                     w_rdAdv, w_rdCommitEn, w_rdRollback, w_ack, w_tokEval;
  InState                   r_state, w_stateNext;
  logic                     r_toggle, r_txValid, r_respHs;
  logic [1:0]               r_respPid;
  logic [CNT_W-1:0]         r_pktCnt;

  usb_ep_in_fifo #(.ADDR_WID(FIFO_ADDR_WID)) u_fifo (
    .clk_i        (clk12_i),
    .rst_i        (rst12_i),
    .wr_en_i      (ep_if.EP_IN_dataValid_i && !STALL_EP),
    .wr_data_i    (ep_if.EP_IN_data_i),
    .fill_done_i  (ep_if.EP_IN_fillTransDone_i),
    .fill_ok_i    (ep_if.EP_IN_fillTransSuccess_i),
    .rd_adv_i     (w_rdAdv),
    .rd_commit_i  (w_rdCommitEn),
    .rd_rollback_i(w_rdRollback),
    .full_o       (w_full),
    .rd_data_o    (w_rdData),
    .rd_o         (w_rd),
    .wr_commit_o  (w_wrCommit),
    .rd_commit_o  (w_rdCommit)
  );

  assign w_inTok   = gotTransStartPacket_i && (transStartTokenID_i == 2'b10) && !STALL_EP;
  assign w_hasData = w_wrCommit != w_rdCommit;
  assign w_pop     = r_txValid && ep_if.txPopData_i;
  assign w_last    = (r_pktCnt == LAST_CNT) || (FIFO_ADDR_WID'(w_rd + 1'b1) == w_wrCommit);

  assign respValid_o                = 1'b1;
  assign respHandshakePID_o         = STALL_EP ? 1'b1 : r_respHs;
  assign respPacketID_o             = STALL_EP ? RES_STALL : r_respPid;
  assign ep_if.EP_IN_full_o         = STALL_EP ? 1'b1 : w_full;
  assign ep_if.txDataAvailable_o    = r_txValid;
  assign ep_if.txData_o             = r_txValid ? w_rdData : 8'h00;
  assign ep_if.txIsLastPacketByte_o = r_txValid && w_last;

  always_comb begin
    w_stateNext  = r_state;
    w_rdAdv      = 1'b0;
    w_rdCommitEn = 1'b0;
    w_rdRollback = 1'b0;
    w_ack        = 1'b0;
    w_tokEval    = 1'b0;
    case (r_state)
      IN_IDLE: w_tokEval = w_inTok;
      IN_SEND: if (w_pop) begin
        w_rdAdv = 1'b1;
        if (w_last) begin
          if (ISO_EP) begin
            w_rdCommitEn = 1'b1;
            w_stateNext  = IN_IDLE;
          end else begin
            w_stateNext  = IN_WAIT_HS;
          end
        end
      end
      IN_WAIT_HS: begin
        if (gotAck_i) begin
          w_rdCommitEn = 1'b1;
          w_ack        = 1'b1;
          w_stateNext  = IN_IDLE;
        end else if (hsTimeout_i || gotTransStartPacket_i) begin
          // Host will retry: rewind, and treat a fresh token as if idle.
          w_rdRollback = 1'b1;
          w_stateNext  = IN_IDLE;
          w_tokEval    = w_inTok;
        end
      end
      default: w_stateNext = IN_IDLE;
    endcase
    if (w_tokEval) begin
      if (w_hasData)     w_stateNext = IN_SEND;
      else if (w_zlpReq) w_stateNext = IN_WAIT_HS;
    end
  end

  always_ff @(posedge clk12_i) begin
    if (rst12_i) begin
      r_state   <= IN_IDLE;
      r_toggle  <= 1'b0;
      r_txValid <= 1'b0;
      r_pktCnt  <= '0;
      r_respHs  <= 1'b1;
      r_respPid <= RES_NAK;
    end else begin
      r_state <= w_stateNext;
      // Data register reloads from mem[rd] every cycle; valid one cycle after entry/pop.
      r_txValid <= (r_state == IN_SEND) && (w_stateNext == IN_SEND) && !w_pop;
      if (w_tokEval)  r_pktCnt <= '0;
      else if (w_pop) r_pktCnt <= r_pktCnt + 1'b1;
      if (ISO_EP || resetDataToggle_i) r_toggle <= 1'b0;
      else if (w_ack)                  r_toggle <= ~r_toggle;
      if (w_tokEval) begin
        if (ISO_EP) begin
          r_respHs  <= 1'b0;
          r_respPid <= DATA0;
        end else begin
          r_respHs  <= !(w_hasData || w_zlpReq);
          r_respPid <= (w_hasData || w_zlpReq) ? (r_toggle ? DATA1 : DATA0) : RES_NAK;
        end
      end
    end
  end

`ifdef USB_EP_IN_ZLP_EN
  logic r_zlpPending, r_zlpSent, r_lastFull;

  assign w_zlpReq = r_zlpPending && !w_hasData && !ISO_EP;

  always_ff @(posedge clk12_i) begin
    if (rst12_i) begin
      r_zlpPending <= 1'b0;
      r_zlpSent    <= 1'b0;
      r_lastFull   <= 1'b0;
    end else begin
      if (w_pop && w_last) r_lastFull <= (r_pktCnt == LAST_CNT);
      if (w_tokEval)       r_zlpSent  <= w_zlpReq && !w_hasData;
      if (w_ack)           r_zlpPending <= !r_zlpSent && r_lastFull && (w_rd == w_wrCommit);
    end
  end
`else
  assign w_zlpReq = 1'b0;
`endif
endmodule

// File: tb/tb_usb_endpoint_in.sv
// Scoreboard bench for usb_endpoint_in: byte-queue reference model, randomized fills and IN transactions.
module tb_usb_endpoint_in;
  import usb_ep_pkg::*;
  import usb_packet_pkg::*;

  localparam int MPS   = 64;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  typedef struct { logic hs; logic [1:0] pid; } resp_t;
  typedef struct { logic [7:0] data; logic last; } tx_t;

  logic       clk = 1'b0, rst = 1'b1;
  logic       tok = 1'b0, rst_tog = 1'b0, ack = 1'b0, hs_to = 1'b0;
  logic [1:0] tok_id = 2'b10;
  logic       resp_valid, resp_hs;
  logic [1:0] resp_pid;

  usb_endpoint_in_if ifc();

  always #5 clk = ~clk;

  usb_endpoint_in #(.EP_TYPE(BULK), .MAX_PACKET_SIZE(MPS), .FIFO_ADDR_WID(AW)) dut (
    .clk12_i              (clk),
    .rst12_i              (rst),
    .gotTransStartPacket_i(tok),
    .transStartTokenID_i  (tok_id),
    .resetDataToggle_i    (rst_tog),
    .ep_if                (ifc),
    .gotAck_i             (ack),
    .hsTimeout_i          (hs_to),
    .respValid_o          (resp_valid),
    .respHandshakePID_o   (resp_hs),
    .respPacketID_o       (resp_pid)
  );

  // Reference model: committed-but-unacked bytes, in-progress fill, toggle, ZLP debt.
  logic [7:0] committed[$];
  logic [7:0] pending[$];
  bit         m_toggle, m_zlp, cur_zlp;
  int         cur_len;
  resp_t      exp_resp[$];
  tx_t        exp_tx[$];
  int         n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: one registered response follows every IN token.
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      if (!rst && tok && tok_id == 2'b10) begin
        @(negedge clk);
        if (exp_resp.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL resp_unexpected: got hs=%0b pid=%0b with no expectation", resp_hs, resp_pid);
        end else begin
          e = exp_resp.pop_front();
          chk("resp_valid", resp_valid, 1'b1);
          chk("resp_hs", resp_hs, e.hs);
          chk("resp_pid", resp_pid, e.pid);
        end
      end
    end
  end

  // Transmitter model and byte monitor: pops every offered byte.
  initial begin
    tx_t e;
    ifc.txPopData_i = 1'b0;
    forever begin
      @(negedge clk);
      ifc.txPopData_i = 1'b0;
      if (!rst && ifc.txDataAvailable_o) begin
        if (exp_tx.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_unexpected: got byte %0h, expected no data", ifc.txData_o);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_data", ifc.txData_o, e.data);
          chk("tx_last", ifc.txIsLastPacketByte_o, e.last);
        end
        ifc.txPopData_i = 1'b1;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_tx.delete(); committed.delete(); pending.delete();
    m_toggle = 0; m_zlp = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic fill(input int n, input bit ok, input bit fixed);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      b = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      ifc.EP_IN_dataValid_i = 1'b1;
      ifc.EP_IN_data_i      = b;
      if (committed.size() + pending.size() < DEPTH - 1) pending.push_back(b);
    end
    @(posedge clk); #1;
    ifc.EP_IN_dataValid_i        = 1'b0;
    ifc.EP_IN_fillTransDone_i    = 1'b1;
    ifc.EP_IN_fillTransSuccess_i = ok;
    if (ok) while (pending.size() > 0) committed.push_back(pending.pop_front());
    else pending.delete();
    @(posedge clk); #1;
    ifc.EP_IN_fillTransDone_i = 1'b0;
    @(negedge clk);
    chk("fifo_full", ifc.EP_IN_full_o, committed.size() >= DEPTH - 1);
  endtask

  task automatic in_token(output bit sent);
    int len;
    @(posedge clk); #1;
    tok = 1'b1; tok_id = 2'b10;
    sent = 1'b1;
    if (committed.size() > 0) begin
      len = (committed.size() < MPS) ? committed.size() : MPS;
      exp_resp.push_back('{1'b0, m_toggle ? 2'b10 : 2'b00});
      for (int i = 0; i < len; i++) exp_tx.push_back('{committed[i], i == len - 1});
      cur_len = len; cur_zlp = 0;
    end else if (m_zlp) begin
      exp_resp.push_back('{1'b0, m_toggle ? 2'b10 : 2'b00});
      cur_len = 0; cur_zlp = 1;
    end else begin
      exp_resp.push_back('{1'b1, 2'b10});
      sent = 1'b0;
    end
    @(posedge clk); #1;
    tok = 1'b0;
  endtask

  // kind: 0 = ACK, 1 = handshake timeout, 2 = leave pending (next token retries)
  task automatic finish_pkt(input int kind);
    int n = 0;
    while (exp_tx.size() != 0 && n < 1000) begin
      @(posedge clk); n++;
    end
    chk("tx_drain_bound", exp_tx.size(), 0);
    exp_tx.delete();
    repeat (2) @(posedge clk);
    #1;
    if (kind == 0) begin
      ack = 1'b1;
      if (cur_zlp) m_zlp = 0;
      else begin
        repeat (cur_len) void'(committed.pop_front());
`ifdef USB_EP_IN_ZLP_EN
        m_zlp = (cur_len == MPS) && (committed.size() == 0);
`endif
      end
      m_toggle = ~m_toggle;
    end else if (kind == 1) begin
      hs_to = 1'b1;
    end
    @(posedge clk); #1;
    ack = 1'b0; hs_to = 1'b0;
  endtask

  task automatic pulse_toggle_reset();
    @(posedge clk); #1;
    rst_tog = 1'b1; m_toggle = 0;
    @(posedge clk); #1;
    rst_tog = 1'b0;
  endtask

  initial begin
    bit sent;
    int guard;
    ifc.EP_IN_fillTransDone_i    = 1'b0;
    ifc.EP_IN_fillTransSuccess_i = 1'b0;
    ifc.EP_IN_dataValid_i        = 1'b0;
    ifc.EP_IN_data_i             = 8'h00;
    do_reset();
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 1'b1);
    chk("rst_resp_hs", resp_hs, 1'b1);
    chk("rst_resp_pid", resp_pid, 2'b10);
    chk("rst_full", ifc.EP_IN_full_o, 1'b0);
    chk("rst_tx_avail", ifc.txDataAvailable_o, 1'b0);
    chk("rst_tx_data", ifc.txData_o, 8'h00);
    chk("rst_tx_last", ifc.txIsLastPacketByte_o, 1'b0);

    in_token(sent);                                  // empty -> NAK
    fill(3, 1, 1);                                   // 11,22,33
    in_token(sent); finish_pkt(0);
    in_token(sent);                                  // empty again -> NAK

    pulse_toggle_reset();
    fill(70, 1, 0);
    in_token(sent); finish_pkt(0);                   // 64 bytes DATA0
    in_token(sent); finish_pkt(0);                   // 6 bytes DATA1

    fill(10, 1, 0);
    in_token(sent); finish_pkt(1);                   // timeout
    in_token(sent); finish_pkt(0);                   // identical resend

    fill(5, 0, 0);
    in_token(sent);                                  // discarded fill -> NAK
    fill(515, 1, 0);                                 // saturates at DEPTH-1
    guard = 0;
    while (committed.size() > 0 && guard < 20) begin
      in_token(sent); if (sent) finish_pkt(0);
      guard++;
    end

    fill(20, 1, 0);
    in_token(sent);
    repeat (10) @(posedge clk);
    do_reset();                                      // mid-packet reset drops everything
    @(negedge clk);
    chk("post_rst_full", ifc.EP_IN_full_o, 1'b0);
    in_token(sent);

`ifdef USB_EP_IN_ZLP_EN
    fill(64, 1, 0);
    in_token(sent); finish_pkt(0);
    in_token(sent); if (sent) finish_pkt(0);         // zero-length DATAx
    in_token(sent);                                  // then NAK
`endif

    repeat (60) begin
      case ($urandom_range(0, 5))
        0, 1: fill($urandom_range(0, 90), $urandom_range(0, 4) != 0, 0);
        2, 3: begin
          in_token(sent);
          if (sent) finish_pkt($urandom_range(0, 2));
        end
        4: pulse_toggle_reset();
        default: begin
          @(posedge clk); #1;
          tok = 1'b1; tok_id = 2'b00;
          @(posedge clk); #1;
          tok = 1'b0; tok_id = 2'b10;
        end
      endcase
    end

    repeat (5) @(posedge clk);
    chk("resp_queue_empty", exp_resp.size(), 0);
    chk("tx_queue_empty", exp_tx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
